sram_port0_ctrl: RTL and testbench

//  Initiator for the RW port (port 0) of the 1rw1r OpenRAM macro (32x2048, byte-masked writes).

---
 rtl/sram_ctrl_pkg.sv | 27 ++
 rtl/sram_rsp_fifo.sv | 63 ++++++
 rtl/sram_port0_ctrl.sv | 147 ++++++++++++++
 tb/tb_sram_port0_ctrl.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared widths, FSM state and request type for the port-0 controller
// of the 1rw1r OpenRAM macro (32x2048, byte-masked writes).
package sram_ctrl_pkg;

    localparam int SRAM_DATA_W     = 32;
    localparam int SRAM_ADDR_W     = 11;
    localparam int SRAM_NUM_WMASKS = 4;
    localparam int SRAM_RSP_DEPTH  = 4;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    typedef struct packed {
        logic                       we;
        logic [SRAM_NUM_WMASKS-1:0] wmask;
        logic [SRAM_ADDR_W-1:0]     addr;
        logic [SRAM_DATA_W-1:0]     wdata;
    } sram_req_t;

    // A slot is free only when buffered plus in-flight reads leave room.
    function automatic logic credit_ok(input int used, input int depth);
        return (used < depth) ? 1'b1 : 1'b0;
    endfunction

endpackage

// File: rtl/sram_rsp_fifo.sv
// Read-response FIFO; push and pop may coincide at any occupancy, including full.
module sram_rsp_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_wdata,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_rdata,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_full;
    logic             w_do_push;
    logic             w_do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? {PW{1'b0}} : p + {{(PW-1){1'b0}}, 1'b1};
    endfunction

    assign w_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == {CW{1'b0}});
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~w_full | w_do_pop);
    assign o_rdata   = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    // Storage, pointers and occupancy.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= {PW{1'b0}};
            r_rd_ptr <= {PW{1'b0}};
            r_count  <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {WIDTH{1'b0}};
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_wdata;
                r_wr_ptr        <= ptr_inc(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + {{(CW-1){1'b0}}, 1'b1};
                2'b01:   r_count <= r_count - {{(CW-1){1'b0}}, 1'b1};
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/sram_port0_ctrl.sv
// Port-0 (RW) initiator for the OpenRAM macro: request stream in, registered macro
// command out, read data returned in order through a credit-managed response FIFO.
module sram_port0_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH    = SRAM_DATA_W,
    parameter int ADDR_WIDTH    = SRAM_ADDR_W,
    parameter int NUM_WMASKS    = SRAM_NUM_WMASKS,
    parameter int RSP_DEPTH     = SRAM_RSP_DEPTH,
    parameter bit INIT_ON_RESET = 1'b1
) (
    input  logic                  clk0,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [NUM_WMASKS-1:0] req_wmask,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  init_done,
    output logic                  csb0,
    output logic                  web0,
    output logic [NUM_WMASKS-1:0] wmask0,
    output logic [ADDR_WIDTH-1:0] addr0,
    output logic [DATA_WIDTH-1:0] din0,
    input  logic [DATA_WIDTH-1:0] dout0
);

    localparam int CW = $clog2(RSP_DEPTH + 1);
    localparam int UW = CW + 1;

    state_e                r_state;
    logic [ADDR_WIDTH-1:0] r_init_addr;
    logic                  r_init_done;
    logic [1:0]            r_rd_pipe;
    logic                  r_csb0;
    logic                  r_web0;
    logic [NUM_WMASKS-1:0] r_wmask0;
    logic [ADDR_WIDTH-1:0] r_addr0;
    logic [DATA_WIDTH-1:0] r_din0;

    logic [CW-1:0]         w_fifo_count;
    logic                  w_fifo_empty;
    logic [UW-1:0]         w_used;
    logic                  w_req_ready;
    logic                  w_accept;
    logic                  w_push;
    logic                  w_pop;

    // r_rd_pipe[0]: read sampled by the macro next edge; r_rd_pipe[1]: dout0 valid this cycle.
    assign w_used      = UW'(w_fifo_count) + UW'(r_rd_pipe[0]) + UW'(r_rd_pipe[1]);
    assign w_req_ready = (r_state == ST_RUN) & credit_ok(int'(w_used), RSP_DEPTH);
    assign w_accept    = req_valid & w_req_ready;
    assign w_push      = r_rd_pipe[1];
    assign w_pop       = ~w_fifo_empty & rsp_ready;

    assign req_ready = w_req_ready;
    assign rsp_valid = ~w_fifo_empty;
    assign init_done = r_init_done;
    assign csb0      = r_csb0;
    assign web0      = r_web0;
    assign wmask0    = r_wmask0;
    assign addr0     = r_addr0;
    assign din0      = r_din0;

    // FSM with the macro command flops: zero-fill sweep, then one request per cycle.
    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_INIT;
            r_init_addr <= {ADDR_WIDTH{1'b0}};
            r_init_done <= 1'b0;
            r_csb0      <= 1'b1;
            r_web0      <= 1'b1;
            r_wmask0    <= {NUM_WMASKS{1'b0}};
            r_addr0     <= {ADDR_WIDTH{1'b0}};
            r_din0      <= {DATA_WIDTH{1'b0}};
        end else begin
            case (r_state)
                ST_INIT: begin
                    if (INIT_ON_RESET) begin
                        r_csb0      <= 1'b0;
                        r_web0      <= 1'b0;
                        r_wmask0    <= {NUM_WMASKS{1'b1}};
                        r_addr0     <= r_init_addr;
                        r_din0      <= {DATA_WIDTH{1'b0}};
                        r_init_addr <= r_init_addr + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                        if (r_init_addr == {ADDR_WIDTH{1'b1}}) begin
                            r_state <= ST_RUN;
                        end else begin
                            r_state <= ST_INIT;
                        end
                    end else begin
                        r_state <= ST_RUN;
                        r_csb0  <= 1'b1;
                        r_web0  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    r_init_done <= 1'b1;
                    if (w_accept) begin
                        r_csb0   <= 1'b0;
                        r_web0   <= ~req_we;
                        r_wmask0 <= req_we ? req_wmask : {NUM_WMASKS{1'b0}};
                        r_addr0  <= req_addr;
                        r_din0   <= req_wdata;
                    end else begin
                        r_csb0   <= 1'b1;
                        r_web0   <= 1'b1;
                        r_wmask0 <= {NUM_WMASKS{1'b0}};
                    end
                end
                default: begin
                    r_state <= ST_INIT;
                    r_csb0  <= 1'b1;
                    r_web0  <= 1'b1;
                end
            endcase
        end
    end

    // Track accepted reads until their data is captured into the FIFO.
    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_pipe <= 2'b00;
        end else begin
            r_rd_pipe <= {r_rd_pipe[0], w_accept & ~req_we};
        end
    end

    sram_rsp_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .i_clk   (clk0),
        .i_rst_n (rst_n),
        .i_push  (w_push),
        .i_wdata (dout0),
        .i_pop   (w_pop),
        .o_rdata (rsp_rdata),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

endmodule

// File: tb/tb_sram_port0_ctrl.sv
// Bench for sram_port0_ctrl: OpenRAM-style macro model, reference memory and
// an in-order response scoreboard; inputs change at posedge+1, outputs sampled at negedge.
module tb_sram_port0_ctrl;
    import sram_ctrl_pkg::*;

    logic        clk0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [3:0]  req_wmask;
    logic [10:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        init_done;
    logic        csb0;
    logic        web0;
    logic [3:0]  wmask0;
    logic [10:0] addr0;
    logic [31:0] din0;
    logic [31:0] dout0;

    sram_port0_ctrl dut (
        .clk0      (clk0),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_wmask (req_wmask),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .init_done (init_done),
        .csb0      (csb0),
        .web0      (web0),
        .wmask0    (wmask0),
        .addr0     (addr0),
        .din0      (din0),
        .dout0     (dout0)
    );

    initial clk0 = 1'b0;
    always #5 clk0 = ~clk0;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int rsp_cnt = 0;
    int acc_cnt = 0;
    logic [31:0] last_rsp;
    logic [31:0] exp_q [$];
    logic [31:0] ref_mem [2048];

    // Macro model: inputs latched at posedge, write then read at the following negedge.
    logic [31:0] mac_mem [2048];
    logic        m_csb;
    logic        m_web;
    logic [3:0]  m_mask;
    logic [10:0] m_addr;
    logic [31:0] m_din;
    logic [31:0] m_tmp;

    initial begin
        m_csb = 1'b1;
        m_web = 1'b1;
        dout0 = 32'h0;
        for (int i = 0; i < 2048; i++) mac_mem[i] = 32'hBAD0_0000 | 32'(i);
    end

    always @(posedge clk0) begin
        cyc    <= cyc + 1;
        m_csb  <= csb0;
        m_web  <= web0;
        m_mask <= wmask0;
        m_addr <= addr0;
        m_din  <= din0;
    end

    always @(negedge clk0) begin
        if (!m_csb && !m_web) begin
            m_tmp = mac_mem[m_addr];
            for (int b = 0; b < 4; b++) if (m_mask[b]) m_tmp[8*b +: 8] = m_din[8*b +: 8];
            mac_mem[m_addr] = m_tmp;
        end
        if (!m_csb && m_web) dout0 <= mac_mem[m_addr];
    end

    // Scoreboard: expectations pushed at accept, popped when a response is taken.
    always @(negedge clk0) begin
        if (rst_n) begin
            if (req_valid && req_ready) begin
                acc_cnt = acc_cnt + 1;
                if (req_we) begin
                    for (int b = 0; b < 4; b++)
                        if (req_wmask[b]) ref_mem[req_addr][8*b +: 8] = req_wdata[8*b +: 8];
                end else begin
                    exp_q.push_back(ref_mem[req_addr]);
                end
            end
            if (rsp_valid && rsp_ready) begin
                checks = checks + 1;
                if (exp_q.size() == 0) begin
                    errors = errors + 1;
                    $display("FAIL sb_unexpected_rsp: got %h, required no response", rsp_rdata);
                end else if (rsp_rdata !== exp_q[0]) begin
                    errors = errors + 1;
                    $display("FAIL sb_rdata: got %h, required %h", rsp_rdata, exp_q[0]);
                    void'(exp_q.pop_front());
                end else begin
                    void'(exp_q.pop_front());
                end
                rsp_cnt  = rsp_cnt + 1;
                last_rsp = rsp_rdata;
            end
        end
    end

    task automatic reset_ref();
        exp_q.delete();
        for (int i = 0; i < 2048; i++) ref_mem[i] = 32'h0;
    endtask

    task automatic send(input sram_req_t r);
        int   n;
        logic ok;
        n  = 0;
        ok = 1'b0;
        req_valid = 1'b1;
        req_we    = r.we;
        req_wmask = r.wmask;
        req_addr  = r.addr;
        req_wdata = r.wdata;
        while (!ok && n < 100) begin
            @(negedge clk0);
            ok = req_ready;
            @(posedge clk0);
            #1;
            n++;
        end
        req_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: addr %h never accepted, req_ready %b required 1", r.addr, req_ready);
        end
    endtask

    task automatic wait_rsps(input int target, output int n);
        n = 0;
        while (rsp_cnt < target && n < 50) begin
            @(posedge clk0);
            #1;
            n++;
        end
    endtask

    task automatic wait_init(output int cnt);
        cnt = 0;
        while (cnt < 3000) begin
            @(posedge clk0);
            cnt++;
            @(negedge clk0);
            if (cnt == 1) begin
                checks++;
                if ({csb0, web0, wmask0, addr0, din0, req_ready} !== {1'b0, 1'b0, 4'hF, 11'h000, 32'h0, 1'b0}) begin
                    errors++;
                    $display("FAIL init_first_cmd: csb/web/mask/addr/din/rdy %b %b %h %h %h %b, required 0 0 f 000 0 0",
                             csb0, web0, wmask0, addr0, din0, req_ready);
                end
            end
            if (cnt == 2048) begin
                checks++;
                if (addr0 !== 11'h7FF || init_done !== 1'b0) begin
                    errors++;
                    $display("FAIL init_last_cmd: addr0 %h init_done %b, required 7ff 0", addr0, init_done);
                end
            end
            if (init_done) break;
        end
        @(posedge clk0);
        #1;
    endtask

    task automatic test_reset();
        int cnt;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_wmask = 4'h0;
        req_addr = 11'h0; req_wdata = 32'h0; rsp_ready = 1'b1;
        reset_ref();
        repeat (3) @(negedge clk0);
        checks++;
        if ({csb0, web0, wmask0, addr0, din0, req_ready, rsp_valid, init_done} !==
            {1'b1, 1'b1, 4'h0, 11'h000, 32'h0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: csb %b web %b mask %h addr %h din %h rdy %b rv %b idone %b, required 1 1 0 000 0 0 0 0",
                     csb0, web0, wmask0, addr0, din0, req_ready, rsp_valid, init_done);
        end
        @(posedge clk0);
        #1;
        rst_n = 1'b1;
        wait_init(cnt);
        checks++;
        if (cnt !== 2049) begin
            errors++;
            $display("FAIL init_cycles: init_done after %0d edges, required 2049", cnt);
        end
    endtask

    task automatic test_init_read();
        int n;
        int start;
        start = rsp_cnt;
        send('{we: 1'b0, wmask: 4'h0, addr: 11'h7FF, wdata: 32'h0});
        wait_rsps(start + 1, n);
        checks++;
        if (rsp_cnt != start + 1 || last_rsp !== 32'h0) begin
            errors++;
            $display("FAIL init_read_7ff: rsps %0d data %h, required 1 rsp 00000000", rsp_cnt - start, last_rsp);
        end
    endtask

    task automatic test_write_read_latency();
        send('{we: 1'b1, wmask: 4'hF, addr: 11'h005, wdata: 32'hDEADBEEF});
        send('{we: 1'b0, wmask: 4'h0, addr: 11'h005, wdata: 32'h0});
        @(negedge clk0);
        @(posedge clk0);
        @(negedge clk0);
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_early: rsp_valid %b one cycle after accept, required 0", rsp_valid);
        end
        @(posedge clk0);
        @(negedge clk0);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL latency_2cyc: rsp_valid %b data %h, required 1 deadbeef", rsp_valid, rsp_rdata);
        end
        @(posedge clk0);
        #1;
    endtask

    task automatic test_byte_mask();
        int n;
        int start;
        start = rsp_cnt;
        send('{we: 1'b1, wmask: 4'b0101, addr: 11'h005, wdata: 32'h11223344});
        send('{we: 1'b0, wmask: 4'h0, addr: 11'h005, wdata: 32'h0});
        wait_rsps(start + 1, n);
        checks++;
        if (rsp_cnt != start + 1 || last_rsp !== 32'hDE22BE44) begin
            errors++;
            $display("FAIL byte_mask: data %h, required de22be44", last_rsp);
        end
        send('{we: 1'b1, wmask: 4'h0, addr: 11'h005, wdata: 32'hFFFFFFFF});
        send('{we: 1'b0, wmask: 4'h0, addr: 11'h005, wdata: 32'h0});
        wait_rsps(start + 2, n);
        checks++;
        if (rsp_cnt != start + 2 || last_rsp !== 32'hDE22BE44) begin
            errors++;
            $display("FAIL zero_mask: data %h rsps %0d, required de22be44 and 2", last_rsp, rsp_cnt - start);
        end
    endtask

    task automatic test_backpressure();
        int idx;
        int start;
        int n;
        for (int i = 0; i < 6; i++)
            send('{we: 1'b1, wmask: 4'hF, addr: 11'h020 + 11'(i), wdata: 32'h2000_0000 + 32'(i)});
        start = rsp_cnt;
        rsp_ready = 1'b0;
        idx = 0;
        req_valid = 1'b1;
        req_we = 1'b0;
        for (int c = 0; c < 12; c++) begin
            req_addr = 11'h020 + 11'(idx);
            @(negedge clk0);
            if (req_ready) idx++;
            @(posedge clk0);
            #1;
            if (idx == 6) break;
        end
        req_valid = 1'b0;
        @(negedge clk0);
        checks++;
        if (idx != 4 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL credit_limit: accepted %0d req_ready %b, required 4 and 0", idx, req_ready);
        end
        repeat (3) @(negedge clk0);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h2000_0000) begin
            errors++;
            $display("FAIL rsp_hold: rsp_valid %b data %h, required 1 20000000", rsp_valid, rsp_rdata);
        end
        @(posedge clk0);
        #1;
        rsp_ready = 1'b1;
        wait_rsps(start + 4, n);
        repeat (5) @(posedge clk0);
        #1;
        checks++;
        if (rsp_cnt != start + 4 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_order: rsps %0d pending %0d, required 4 and 0", rsp_cnt - start, exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int n;
        int start;
        int t0;
        start = rsp_cnt;
        send('{we: 1'b1, wmask: 4'hF, addr: 11'h010, wdata: 32'hA5A5A5A5});
        t0 = cyc;
        send('{we: 1'b0, wmask: 4'h0, addr: 11'h010, wdata: 32'h0});
        wait_rsps(start + 1, n);
        checks++;
        if (last_rsp !== 32'hA5A5A5A5 || rsp_cnt != start + 1) begin
            errors++;
            $display("FAIL raw_b2b: data %h, required a5a5a5a5", last_rsp);
        end
        checks++;
        if (cyc - t0 - n != 1) begin
            errors++;
            $display("FAIL raw_b2b_gap: read took %0d cycles to accept, required 1", cyc - t0 - n);
        end
        start = rsp_cnt;
        t0 = cyc;
        for (int i = 0; i < 8; i++)
            send('{we: 1'b0, wmask: 4'h0, addr: 11'h020 + 11'(i % 6), wdata: 32'h0});
        checks++;
        if (cyc - t0 != 8) begin
            errors++;
            $display("FAIL throughput: 8 reads took %0d cycles, required 8", cyc - t0);
        end
        wait_rsps(start + 8, n);
        checks++;
        if (rsp_cnt != start + 8) begin
            errors++;
            $display("FAIL throughput_rsps: got %0d responses, required 8", rsp_cnt - start);
        end
    endtask

    task automatic test_reset_mid();
        int cnt;
        int n;
        int start;
        send('{we: 1'b0, wmask: 4'h0, addr: 11'h020, wdata: 32'h0});
        send('{we: 1'b0, wmask: 4'h0, addr: 11'h021, wdata: 32'h0});
        rst_n = 1'b0;
        #1;
        checks++;
        if (csb0 !== 1'b1 || req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: csb0 %b req_ready %b rsp_valid %b, required 1 0 0", csb0, req_ready, rsp_valid);
        end
        reset_ref();
        start = rsp_cnt;
        repeat (2) @(posedge clk0);
        #1;
        rst_n = 1'b1;
        wait_init(cnt);
        checks++;
        if (cnt !== 2049 || rsp_cnt != start) begin
            errors++;
            $display("FAIL reset_rerun: init edges %0d rsps %0d, required 2049 and 0", cnt, rsp_cnt - start);
        end
        send('{we: 1'b0, wmask: 4'h0, addr: 11'h010, wdata: 32'h0});
        wait_rsps(start + 1, n);
        checks++;
        if (rsp_cnt != start + 1 || last_rsp !== 32'h0) begin
            errors++;
            $display("FAIL rezeroed: data %h, required 00000000", last_rsp);
        end
    endtask

    initial begin
        test_reset();
        test_init_read();
        test_write_read_latency();
        test_byte_mask();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        repeat (3) @(posedge clk0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
